// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: buffers characters with their error flags
// and derives the trigger, overrun, error-in-FIFO and character-timeout indications.
module uart_rx_fifo #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned TIMEOUT_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_pulse,
    input  logic                     push_in,
    input  logic [7:0]               din,
    input  logic                     pe_in,
    input  logic                     fe_in,
    input  logic                     bi_in,
    input  logic                     pop,
    input  logic                     fifo_en,
    input  logic                     fifo_clr,
    input  logic                     ovr_clr,
    input  logic [1:0]               rx_trig,
    output logic [7:0]               dout,
    output logic                     pe_out,
    output logic                     fe_out,
    output logic                     bi_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     trig_hit,
    output logic                     err_in_fifo,
    output logic                     timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          overrun_q, overrun_d;
    logic          fifo_en_q;

    logic [CW-1:0] cap;
    logic [10:0]   head;
    logic          head_err, push_err;
    logic          push_acc, pop_acc, clr;
    int unsigned   lvl;

    assign cap      = fifo_en ? CW'(DEPTH) : CW'(1);
    assign empty    = (count_q == '0);
    assign full     = (count_q == cap);
    assign count    = count_q;
    assign overrun  = overrun_q;
    assign head     = mem[rd_ptr_q];
    assign head_err = |head[10:8];
    assign push_err = pe_in | fe_in | bi_in;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts push+pop.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push_in & (~full | pop_acc);
    assign clr      = fifo_clr | (fifo_en != fifo_en_q);

    assign dout   = empty ? 8'h00 : head[7:0];
    assign pe_out = ~empty & head[8];
    assign fe_out = ~empty & head[9];
    assign bi_out = ~empty & head[10];

    always_comb begin
        lvl = 1;
        unique case (rx_trig)
            2'b00: lvl = 1;
            2'b01: lvl = 4;
            2'b10: lvl = 8;
            2'b11: lvl = 14;
            default: lvl = 1;
        endcase
        if (lvl > 32'(cap)) lvl = 32'(cap);
    end

    assign trig_hit    = fifo_en ? (32'(count_q) >= lvl) : ~empty;
    assign err_in_fifo = (err_cnt_q != '0);
    assign timeout     = fifo_en & (tcnt_q == TMAX);

    always_comb begin
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        tcnt_d    = tcnt_q;
        overrun_d = overrun_q;

        if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
        else if (pop_acc && !push_acc) count_d = count_q - CW'(1);

        if ((push_acc && push_err) && !(pop_acc && head_err))      err_cnt_d = err_cnt_q + CW'(1);
        else if ((pop_acc && head_err) && !(push_acc && push_err)) err_cnt_d = err_cnt_q - CW'(1);

        if (push_acc || pop_acc || empty)       tcnt_d = '0;
        else if (baud_pulse && tcnt_q != TMAX) tcnt_d = tcnt_q + TW'(1);

        // Set beats clear when an overflow coincides with ovr_clr.
        if (ovr_clr) overrun_d = 1'b0;
        if (push_in && !push_acc && !clr) overrun_d = 1'b1;

        if (clr) begin
            count_d   = '0;
            err_cnt_d = '0;
            tcnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
            tcnt_q    <= '0;
            overrun_q <= 1'b0;
            fifo_en_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            tcnt_q    <= tcnt_d;
            overrun_q <= overrun_d;
            fifo_en_q <= fifo_en;
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_acc)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage is not reset; only pointers and count define its validity.
    always_ff @(posedge clk) begin
        if (push_acc && !clr) mem[wr_ptr_q] <= {bi_in, fe_in, pe_in, din};
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo with hand sequences for
// fill/overrun, trigger levels, non-FIFO mode, character timeout and async reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse, push_in, pe_in, fe_in, bi_in, pop;
    logic       fifo_en, fifo_clr, ovr_clr;
    logic [7:0] din;
    logic [1:0] rx_trig;
    logic [7:0] dout;
    logic       pe_out, fe_out, bi_out, empty, full, overrun, trig_hit, err_in_fifo, timeout;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16), .TIMEOUT_TICKS(640)) dut (
        .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .push_in(push_in), .din(din),
        .pe_in(pe_in), .fe_in(fe_in), .bi_in(bi_in), .pop(pop), .fifo_en(fifo_en),
        .fifo_clr(fifo_clr), .ovr_clr(ovr_clr), .rx_trig(rx_trig), .dout(dout),
        .pe_out(pe_out), .fe_out(fe_out), .bi_out(bi_out), .empty(empty), .full(full),
        .count(count), .overrun(overrun), .trig_hit(trig_hit), .err_in_fifo(err_in_fifo),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [7:0] din;
        logic [2:0] flg;   // {bi,fe,pe}
        logic       pop;
        logic       clr;
        logic [1:0] trig;
        int         cnt;
        logic [7:0] dout;
        logic [2:0] oflg;
        logic       trig_hit;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        push_in = 1'b0; pop = 1'b0; fifo_clr = 1'b0; ovr_clr = 1'b0; baud_pulse = 1'b0;
        pe_in = 1'b0; fe_in = 1'b0; bi_in = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] d);
        push_in = 1'b1; din = d;
        cyc();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        cyc();
    endtask

    initial begin
        rst = 1'b1; baud_pulse = 0; push_in = 0; pe_in = 0; fe_in = 0; bi_in = 0; pop = 0;
        fifo_en = 1'b1; fifo_clr = 0; ovr_clr = 0; din = 8'h00; rx_trig = 2'b00;

        vecs[0]  = '{1, 8'hA5, 3'b000, 0, 0, 2'b00, 1, 8'hA5, 3'b000, 1, 0};
        vecs[1]  = '{0, 8'h00, 3'b000, 1, 0, 2'b00, 0, 8'h00, 3'b000, 0, 0};
        vecs[2]  = '{1, 8'h11, 3'b000, 0, 0, 2'b01, 1, 8'h11, 3'b000, 0, 0};
        vecs[3]  = '{1, 8'h22, 3'b010, 0, 0, 2'b01, 2, 8'h11, 3'b000, 0, 1};
        vecs[4]  = '{1, 8'h33, 3'b000, 0, 0, 2'b01, 3, 8'h11, 3'b000, 0, 1};
        vecs[5]  = '{1, 8'h44, 3'b000, 0, 0, 2'b01, 4, 8'h11, 3'b000, 1, 1};
        vecs[6]  = '{0, 8'h00, 3'b000, 1, 0, 2'b01, 3, 8'h22, 3'b010, 0, 1};
        vecs[7]  = '{0, 8'h00, 3'b000, 1, 0, 2'b01, 2, 8'h33, 3'b000, 0, 0};
        vecs[8]  = '{1, 8'h55, 3'b000, 1, 0, 2'b01, 2, 8'h44, 3'b000, 0, 0};
        vecs[9]  = '{1, 8'h66, 3'b001, 1, 0, 2'b01, 2, 8'h55, 3'b000, 0, 1};
        vecs[10] = '{1, 8'h77, 3'b000, 0, 1, 2'b00, 0, 8'h00, 3'b000, 0, 0};
        vecs[11] = '{0, 8'h00, 3'b000, 1, 0, 2'b00, 0, 8'h00, 3'b000, 0, 0};
        vecs[12] = '{1, 8'h88, 3'b000, 1, 0, 2'b00, 1, 8'h88, 3'b000, 1, 0};
        vecs[13] = '{0, 8'h00, 3'b000, 0, 1, 2'b00, 0, 8'h00, 3'b000, 0, 0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc(); cyc();

        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_err", 32'(err_in_fifo), 0);
        chk("rst_dout", 32'(dout), 0);

        for (int i = 0; i < 14; i++) begin
            push_in = vecs[i].push; din = vecs[i].din;
            {bi_in, fe_in, pe_in} = vecs[i].flg;
            pop = vecs[i].pop; fifo_clr = vecs[i].clr; rx_trig = vecs[i].trig;
            cyc();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].dout));
            chk($sformatf("v%0d_flags", i), 32'({bi_out, fe_out, pe_out}), 32'(vecs[i].oflg));
            chk($sformatf("v%0d_trig", i), 32'(trig_hit), 32'(vecs[i].trig_hit));
            chk($sformatf("v%0d_err", i), 32'(err_in_fifo), 32'(vecs[i].err));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
            chk($sformatf("v%0d_ovr", i), 32'(overrun), 0);
        end

        // Fill to capacity, overflow, drain in order
        rx_trig = 2'b00;
        for (int i = 0; i < 16; i++) do_push(8'(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        chk("fill_ovr0", 32'(overrun), 0);
        do_push(8'hFF);
        chk("ovf_overrun", 32'(overrun), 1);
        chk("ovf_count", 32'(count), 16);
        push_in = 1'b1; din = 8'hFF; ovr_clr = 1'b1;
        cyc();
        chk("ovf_set_wins", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), 32'(dout), 32'(i));
            do_pop();
        end
        chk("drain_empty", 32'(empty), 1);
        ovr_clr = 1'b1;
        cyc();
        chk("ovr_clr", 32'(overrun), 0);

        // Trigger level 14
        rx_trig = 2'b11;
        for (int i = 0; i < 13; i++) do_push(8'h30 + 8'(i));
        chk("trig14_13", 32'(trig_hit), 0);
        do_push(8'h3D);
        chk("trig14_14", 32'(trig_hit), 1);
        do_pop();
        chk("trig14_pop", 32'(trig_hit), 0);
        chk("trig14_cnt", 32'(count), 13);

        // Mode change flushes implicitly; then single holding register
        fifo_en = 1'b0;
        cyc();
        chk("mode_clr_cnt", 32'(count), 0);
        do_push(8'h55);
        chk("nf_count", 32'(count), 1);
        chk("nf_full", 32'(full), 1);
        chk("nf_trig", 32'(trig_hit), 1);
        do_push(8'h66);
        chk("nf_ovr", 32'(overrun), 1);
        chk("nf_dout", 32'(dout), 32'h55);
        chk("nf_cnt1", 32'(count), 1);
        push_in = 1'b1; din = 8'h77; pop = 1'b1;
        cyc();
        chk("nf_swap_dout", 32'(dout), 32'h77);
        chk("nf_swap_ovr", 32'(overrun), 1);
        chk("nf_swap_cnt", 32'(count), 1);
        fifo_en = 1'b1;
        cyc();
        chk("mode_back_cnt", 32'(count), 0);
        chk("mode_keeps_ovr", 32'(overrun), 1);

        // Character timeout
        do_push(8'hC3);
        for (int i = 0; i < 639; i++) begin
            baud_pulse = 1'b1;
            cyc();
            cyc();
        end
        chk("to_639", 32'(timeout), 0);
        baud_pulse = 1'b1;
        cyc();
        chk("to_640", 32'(timeout), 1);
        cyc();
        chk("to_hold", 32'(timeout), 1);
        do_pop();
        chk("to_drop", 32'(timeout), 0);

        // Asynchronous reset mid-operation
        fe_in = 1'b1;
        do_push(8'h9A);
        do_push(8'h9B);
        chk("pre_rst_err", 32'(err_in_fifo), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_dout", 32'(dout), 0);
        chk("arst_ovr", 32'(overrun), 0);
        chk("arst_err", 32'(err_in_fifo), 0);
        chk("arst_to", 32'(timeout), 0);
        #10 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
